// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues word requests to instruction memory, buffers
// returned instructions with their PC and hands them to decode; redirects flush.
module fetch_stage #(
    parameter int unsigned           D_WIDTH    = 32,
    parameter logic [D_WIDTH-1:0]    RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [D_WIDTH-1:0] redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [D_WIDTH-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [D_WIDTH-1:0] id_instr,
    output logic [D_WIDTH-1:0] id_pc
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [D_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      drop_cnt_q, drop_cnt_d;

    logic [D_WIDTH-1:0] instr_q [FIFO_DEPTH];
    logic [D_WIDTH-1:0] ipc_q   [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [D_WIDTH-1:0] pcq_q [FIFO_DEPTH];
    logic [AW-1:0]      pcq_wr_q, pcq_wr_d;
    logic [AW-1:0]      pcq_rd_q, pcq_rd_d;

    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic               req_fire;
    logic               rsp_live;
    logic [CW:0]        credit_used;

    assign fifo_empty = (count_q == '0);
    assign id_valid   = !rst && !fifo_empty;
    assign pop        = id_valid && id_ready;
    assign id_instr   = id_valid ? instr_q[rd_ptr_q] : '0;
    assign id_pc      = id_valid ? ipc_q[rd_ptr_q]   : '0;

    // A pop this cycle frees its slot immediately, so a full pipe still issues
    // one request per cycle while decode keeps accepting.
    assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
    assign imem_req_valid = !rst && (state_q == S_FETCH) && fetch_en && !redirect_valid
                            && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. from before a reset) are ignored.
    assign rsp_live = imem_rsp_valid && (inflight_q != '0);
    assign push     = rsp_live && !redirect_valid && (drop_cnt_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = fetch_en ? S_FETCH : S_HALT;
            S_HALT:  state_d = fetch_en ? S_FETCH : S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~D_WIDTH'(3);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + D_WIDTH'(4);
        end

        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_live);

        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = inflight_d;
        end else if (rsp_live && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        pcq_wr_d = pcq_wr_q + AW'(req_fire);
        pcq_rd_d = pcq_rd_q + AW'(rsp_live);

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= '0;
                ipc_q[i]   <= '0;
                pcq_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            if (req_fire) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
            end
            if (push) begin
                instr_q[wr_ptr_q] <= imem_rsp_data;
                ipc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
            end
        end
    end

endmodule
